// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the ccff bitstream loader: FSM state encoding,
// CRC-16-CCITT constants and the bit-serial CRC update step.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } ccff_state_e;

  // Plain-vector views of the state encoding, used by the FSM registers
  // and by anything that watches the debug state port.
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_LOAD   = LOAD;
  localparam logic [1:0] S_VERIFY = VERIFY;
  localparam logic [1:0] S_DONE   = DONE;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One bit of CRC-16-CCITT, MSB-first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator. clear reloads the init value and
// takes priority over en; en folds one bit in per clock.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // Accumulate one bit per enabled cycle, restart on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver for the fabric ccff shift chain.
// Accepts bytes on a valid/ready stream, serializes them MSB first onto
// ccff_head with ccff_shift_en high for exactly CHAIN_LEN bits, and
// optionally recirculates the chain once to compare a readback CRC.
// Build option: define CCFF_READBACK_EN to include the VERIFY pass.
//
// Handshake: a byte moves when cfg_valid && cfg_ready are both high at a
// rising prog_clk edge. cfg_ready never depends on cfg_valid; cfg_data is
// only looked at on a handshake edge.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       verify_ok,
  output logic       verify_err,
  output logic [1:0] state_dbg
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int BYTE_W = $clog2(NBYTES + 1);
  // Bits taken from the final byte; the low leftovers are dropped.
  localparam logic [3:0] LAST_BITS = (CHAIN_LEN % 8 == 0) ? 4'd8 : 4'(CHAIN_LEN % 8);

`ifdef CCFF_READBACK_EN
  localparam logic [1:0] S_AFTER_LOAD = S_VERIFY;
`else
  localparam logic [1:0] S_AFTER_LOAD = S_DONE;
`endif

  logic [1:0]       state_q;
  logic [7:0]       buf_q;
  logic [3:0]       fill_q;
  logic [BYTE_W-1:0] bytes_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             head_q;
  logic             shift_en_q;

  logic start_go;
  logic emit;
  logic accept;
  logic last_byte;
  logic load_end;
  logic verify_last;

  assign start_go    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign emit        = (state_q == S_LOAD) && (fill_q != 4'd0);
  assign cfg_ready   = (state_q == S_LOAD) && (fill_q <= 4'd1) && (bytes_q < BYTE_W'(NBYTES));
  assign accept      = cfg_valid && cfg_ready;
  assign last_byte   = (bytes_q == BYTE_W'(NBYTES - 1));
  // The head is registered, so LOAD lingers one cycle after the last emit
  // to let the final shift_en cycle reach the chain before moving on.
  assign load_end    = (state_q == S_LOAD) && (bit_cnt == CNT_W'(CHAIN_LEN));
  assign verify_last = (state_q == S_VERIFY) && (bit_cnt == CNT_W'(CHAIN_LEN - 1));

  assign busy      = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

  // Control FSM plus the byte buffer and the registered head/shift_en.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q    <= S_IDLE;
      buf_q      <= 8'd0;
      fill_q     <= 4'd0;
      bytes_q    <= '0;
      bit_cnt    <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      shift_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_go) begin
            state_q <= S_LOAD;
            fill_q  <= 4'd0;
            bytes_q <= '0;
            bit_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (emit) begin
            head_q     <= buf_q[7];
            shift_en_q <= 1'b1;
            bit_cnt    <= bit_cnt + 1'b1;
          end
          if (accept) begin
            buf_q   <= cfg_data;
            fill_q  <= last_byte ? LAST_BITS : 4'd8;
            bytes_q <= bytes_q + 1'b1;
          end else if (emit) begin
            buf_q  <= {buf_q[6:0], 1'b0};
            fill_q <= fill_q - 4'd1;
          end
          if (load_end) begin
            state_q <= S_AFTER_LOAD;
            bit_cnt <= '0;
          end
        end
        S_VERIFY: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (verify_last) begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic [15:0] load_crc;
  logic [15:0] rb_crc;
  logic        rb_match;
  logic        verify_ok_q;
  logic        verify_err_q;

  // CRC of exactly the bits the chain was clocked with.
  ccff_crc16_serial u_load_crc (
    .clk   (prog_clk),
    .rst   (prog_reset),
    .clear (start_go),
    .en    (shift_en_q),
    .din   (head_q),
    .crc   (load_crc)
  );

  // CRC of the bits coming out of the chain during the recirculation pass.
  ccff_crc16_serial u_rb_crc (
    .clk   (prog_clk),
    .rst   (prog_reset),
    .clear (start_go),
    .en    (state_q == S_VERIFY),
    .din   (ccff_tail),
    .crc   (rb_crc)
  );

  // The last tail bit is still on the wire at the exit edge, so fold it in here.
  assign rb_match = (crc16_step(rb_crc, ccff_tail) == load_crc);

  // Latch the readback verdict on the final VERIFY cycle; a new start clears it.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      verify_ok_q  <= 1'b0;
      verify_err_q <= 1'b0;
    end else if (start_go) begin
      verify_ok_q  <= 1'b0;
      verify_err_q <= 1'b0;
    end else if (verify_last) begin
      verify_ok_q  <= rb_match;
      verify_err_q <= !rb_match;
    end
  end

  assign verify_ok     = verify_ok_q;
  assign verify_err    = verify_err_q;
  // During VERIFY the chain is fed its own output so it ends where it began.
  assign ccff_head     = (state_q == S_VERIFY) ? ccff_tail : head_q;
  assign ccff_shift_en = (state_q == S_VERIFY) || shift_en_q;
`else
  logic unused_tail;
  assign unused_tail   = ccff_tail;
  assign verify_ok     = 1'b0;
  assign verify_err    = 1'b0;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
`endif

endmodule
